spi_master_n: RTL and testbench
===============================

Name: spi_master_n

Overview:
- Parametrised SPI master; successor to the fixed 24-bit, clk/2, transmit-only SPI word sender.
- Adds configurable word width, SCL divider and idle polarity, full-duplex MISO capture, and ready/done handshake.
- Adds optional built-in chip-select generation.
- Sits between a register/command sequencer and an external SPI peripheral (DAC, ADC, driver chip).

Parameters:
- WIDTH, 24: bits per transaction; legal range 2..64.
- DIV, 1: SCL half-period in clk cycles; legal range 1..255. DIV=1 gives SCL at clk/2.
- CPOL, 1: SCL idle level.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- we  in  1  start request; sampled only while ready=1.
- tx  in  WIDTH  word to send; latched on the accepting cycle.
- ready  out  1  high in IDLE; we is accepted only when high.
- running  out  1  high from the cycle after acceptance until return to IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- rx  out  WIDTH  received word; valid from the done cycle; held until the next done.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SCL  out  1  serial clock.
- CS_n  out  1  chip select, active low. Present only with SPIM_CS_EN.

Behaviour:
- Reset (async assert, sync release) takes effect immediately, including mid-transfer; the partial word is discarded and no done pulse is issued. Reset values: SCL=CPOL, MOSI=0, ready=1, running=0, done=0, rx=0, CS_n=1.
- States:
  - IDLE: ready=1. On we, latch tx into the shift register, zero the bit counter, go to LEAD (with SPIM_CS_EN) or XFER (without).
  - LEAD: lasts DIV cycles, then XFER.
  - XFER: 2*WIDTH half-periods of DIV cycles each.
  - TAIL: lasts DIV cycles, then IDLE.
- Mode is CPHA=0:
  - MOSI presents the first bit from XFER entry while SCL is idle.
  - The slave samples on the leading edge (idle->active).
  - The master samples MISO into the rx shift register at the clk edge that drives the SCL leading edge.
  - MOSI advances to the next bit on each trailing edge, except after the last bit.
- Counters:
  - Divider counter of width clog2(DIV+1) reloads at each half-period boundary.
  - Bit counter of width clog2(WIDTH+1) increments on each trailing edge.
  - XFER ends on the trailing edge that brings the bit count to WIDTH.
- The last trailing edge returns SCL to CPOL.
  - Without SPIM_CS_EN: done=1 and rx updated in the following cycle, which is the first IDLE cycle. ready=1 in that same cycle.
  - With SPIM_CS_EN: TAIL follows, then done on IDLE entry.
- Latency, with accept at cycle 0:
  - First leading edge at cycle 1+DIV (plus DIV with SPIM_CS_EN).
  - Total busy time: 2*WIDTH*DIV cycles (plus 2*DIV with SPIM_CS_EN).
- we while ready=0 is ignored; no queueing. we in the done cycle is accepted, because ready=1 then: back-to-back transfers with no idle SCL gap beyond the SCL idle level.
- tx changes after acceptance have no effect. MOSI=0 while IDLE. MISO is ignored outside XFER.
- LSB-first (MSB_FIRST=0) mirrors both shift directions; rx is bit-ordered as transmitted.

Optional Feature:
- Macro SPIM_CS_EN.
- Defined:
  - CS_n port exists. CS_n falls on the cycle after acceptance (LEAD entry).
  - Setup of DIV cycles before the first leading edge; hold of DIV cycles after the last trailing edge (TAIL).
  - CS_n rises with done. Back-to-back accepts still force CS_n high for at least 1 cycle.
- Undefined: no CS_n port, no LEAD/TAIL states; the surrounding logic owns chip select.

Test Plan:
- WIDTH=24, DIV=1, CPOL=1, macro off. we with tx=24'hA5C381, MISO looped to MOSI -> 24 SCL pulses at clk/2, MOSI bit sequence 1010_0101..., done at cycle 49, rx=24'hA5C381.
- WIDTH=8, DIV=3, CPOL=0. tx=8'h3C, MISO tied 1 -> each SCL phase 3 cycles, idle low, busy 48 cycles, rx=8'hFF.
- WIDTH=16, MSB_FIRST=0. tx=16'h0001 -> first MOSI bit 1, remaining 15 bits 0.
- we held high continuously; tx changed mid-transfer -> second transfer starts in the done cycle, transmits the tx value present in that cycle, first word unaffected.
- resetn low at bit 10 of a 24-bit transfer -> SCL=CPOL, ready=1, no done, rx unchanged (0).
- SPIM_CS_EN, DIV=2, WIDTH=8 -> CS_n low 2 cycles before the first SCL edge, high 2 cycles after the last, total low 36 cycles, done coincident with CS_n rise.

Source files
------------

// File: rtl/spi_master_n.sv
// Parametrised CPHA=0 SPI master: full-duplex shift, configurable width/divider/polarity.
// Optional chip-select generation with LEAD/TAIL setup and hold phases under `SPIM_CS_EN.
module spi_master_n #(
    parameter int WIDTH     = 24,
    parameter int DIV       = 1,
    parameter int CPOL      = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [WIDTH-1:0] tx,
    output logic             ready,
    output logic             running,
    output logic             done,
    output logic [WIDTH-1:0] rx,
    output logic             MOSI,
    input  logic             MISO,
    output logic             SCL
`ifdef SPIM_CS_EN
    ,
    output logic             CS_n
`endif
);

    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_M1   = DW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic          SCL_IDLE = (CPOL != 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd2;
`ifdef SPIM_CS_EN
    localparam logic [1:0] LEAD = 2'd1;
    localparam logic [1:0] TAIL = 2'd3;
`endif

    logic [1:0]       r_state;
    logic [DW-1:0]    r_div;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_txsh;
    logic [WIDTH-1:0] r_rxsh;
    logic [WIDTH-1:0] r_rx;
    logic             r_scl;
    logic             r_done;
`ifdef SPIM_CS_EN
    logic             r_cs_n;
`endif
    logic             w_tx_bit;

    assign w_tx_bit = (MSB_FIRST != 0) ? r_txsh[WIDTH-1] : r_txsh[0];
    assign MOSI     = (r_state == XFER) && w_tx_bit;
    assign SCL      = r_scl;
    assign ready    = (r_state == IDLE);
    assign running  = (r_state != IDLE);
    assign done     = r_done;
    assign rx       = r_rx;
`ifdef SPIM_CS_EN
    assign CS_n     = r_cs_n;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_txsh  <= '0;
            r_rxsh  <= '0;
            r_rx    <= '0;
            r_scl   <= SCL_IDLE;
            r_done  <= 1'b0;
`ifdef SPIM_CS_EN
            r_cs_n  <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (we) begin
                        r_txsh <= tx;
                        r_bit  <= '0;
                        r_div  <= DIV_M1;
`ifdef SPIM_CS_EN
                        r_state <= LEAD;
                        r_cs_n  <= 1'b0;
`else
                        r_state <= XFER;
`endif
                    end
                end
`ifdef SPIM_CS_EN
                LEAD: begin
                    if (r_div == '0) begin
                        r_div   <= DIV_M1;
                        r_state <= XFER;
                    end else begin
                        r_div <= r_div - DW'(1);
                    end
                end
`endif
                XFER: begin
                    if (r_div != '0) begin
                        r_div <= r_div - DW'(1);
                    end else begin
                        r_div <= DIV_M1;
                        r_scl <= ~r_scl;
                        // SCL still at idle level: this edge is the leading edge, sample MISO
                        if (r_scl == SCL_IDLE) begin
                            if (MSB_FIRST != 0)
                                r_rxsh <= {r_rxsh[WIDTH-2:0], MISO};
                            else
                                r_rxsh <= {MISO, r_rxsh[WIDTH-1:1]};
                        end else begin
                            r_bit <= r_bit + BW'(1);
                            if (r_bit == LAST_BIT) begin
`ifdef SPIM_CS_EN
                                r_state <= TAIL;
`else
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                                r_rx    <= r_rxsh;
`endif
                            end else if (MSB_FIRST != 0) begin
                                r_txsh <= {r_txsh[WIDTH-2:0], 1'b0};
                            end else begin
                                r_txsh <= {1'b0, r_txsh[WIDTH-1:1]};
                            end
                        end
                    end
                end
`ifdef SPIM_CS_EN
                TAIL: begin
                    if (r_div == '0) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_rx    <= r_rxsh;
                        r_cs_n  <= 1'b1;
                    end else begin
                        r_div <= r_div - DW'(1);
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_n.sv
// Self-checking bench for spi_master_n: three parameterisations checked cycle by cycle
// against a waveform model derived from cycle index arithmetic.
module tb_spi_master_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [2:0]  we_v, ready_v, running_v, done_v, mosi_v, scl_v, csn_v, miso_v;
    logic [2:0]  loop_v, miso_drv;
    logic [23:0] tx0, rx0;
    logic [7:0]  tx1, rx1;
    logic [15:0] tx2, rx2;

    int checks = 0;
    int errors = 0;
    logic [63:0] prev_rx [3];
    bit          samp [0:4095];

`ifdef SPIM_CS_EN
    localparam bit CSEN = 1'b1;
`else
    localparam bit CSEN = 1'b0;
    assign csn_v = '1;
`endif

    assign miso_v = (loop_v & mosi_v) | (~loop_v & miso_drv);

    spi_master_n #(.WIDTH(24), .DIV(1), .CPOL(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .resetn(resetn), .we(we_v[0]), .tx(tx0), .ready(ready_v[0]),
        .running(running_v[0]), .done(done_v[0]), .rx(rx0), .MOSI(mosi_v[0]),
        .MISO(miso_v[0]), .SCL(scl_v[0])
`ifdef SPIM_CS_EN
        , .CS_n(csn_v[0])
`endif
    );

    spi_master_n #(.WIDTH(8), .DIV(3), .CPOL(0), .MSB_FIRST(1)) u_b (
        .clk(clk), .resetn(resetn), .we(we_v[1]), .tx(tx1), .ready(ready_v[1]),
        .running(running_v[1]), .done(done_v[1]), .rx(rx1), .MOSI(mosi_v[1]),
        .MISO(miso_v[1]), .SCL(scl_v[1])
`ifdef SPIM_CS_EN
        , .CS_n(csn_v[1])
`endif
    );

    spi_master_n #(.WIDTH(16), .DIV(2), .CPOL(1), .MSB_FIRST(0)) u_c (
        .clk(clk), .resetn(resetn), .we(we_v[2]), .tx(tx2), .ready(ready_v[2]),
        .running(running_v[2]), .done(done_v[2]), .rx(rx2), .MOSI(mosi_v[2]),
        .MISO(miso_v[2]), .SCL(scl_v[2])
`ifdef SPIM_CS_EN
        , .CS_n(csn_v[2])
`endif
    );

    function automatic int pw(input int u);
        return (u == 0) ? 24 : (u == 1) ? 8 : 16;
    endfunction
    function automatic int pd(input int u);
        return (u == 0) ? 1 : (u == 1) ? 3 : 2;
    endfunction
    function automatic bit pc(input int u);
        return (u != 1);
    endfunction
    function automatic bit pm(input int u);
        return (u != 2);
    endfunction

    function automatic logic [63:0] get_rx(input int u);
        case (u)
            0:       return 64'(rx0);
            1:       return 64'(rx1);
            default: return 64'(rx2);
        endcase
    endfunction

    task automatic set_tx(input int u, input logic [63:0] v);
        case (u)
            0:       tx0 = v[23:0];
            1:       tx1 = v[7:0];
            default: tx2 = v[15:0];
        endcase
    endtask

    // i-th bit in transmission order
    function automatic bit word_bit(input logic [63:0] w, input int width, input bit msb, input int i);
        return msb ? w[width-1-i] : w[i];
    endfunction

    // Drives one transaction from the accept cycle (c=0) through the done cycle (c=B+1),
    // comparing every output against the model each cycle. miso_mode: 0 random, 1 tied high.
    task automatic run_one(input int u, input logic [63:0] word, input bit keep_we,
                           input logic [63:0] next_tx, input int change_at,
                           input int abort_at, input bit miso_mode);
        int W, D, L, B, k, half;
        bit cp, e_scl, e_mosi, e_run, b;
        logic [63:0] e_rx;
        W = pw(u); D = pd(u); cp = pc(u);
        L = CSEN ? D : 0;
        B = 2 * W * D + 2 * L;

        we_v[u] = 1'b1;
        set_tx(u, word);
        miso_drv[u] = miso_mode ? 1'b1 : 1'($urandom);
        samp[0] = miso_drv[u];
        checks++;
        if (ready_v[u] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready u%0d: got %b expected 1", u, ready_v[u]);
        end

        for (int c = 1; c <= B + 1; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                we_v[u] = 1'b0;
                resetn = 1'b0;
                #1;
                checks++;
                if (scl_v[u] !== cp || mosi_v[u] !== 1'b0 || ready_v[u] !== 1'b1 ||
                    running_v[u] !== 1'b0 || done_v[u] !== 1'b0 || get_rx(u) !== 64'd0 ||
                    csn_v[u] !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_state u%0d: got scl=%b mosi=%b rdy=%b run=%b done=%b rx=%0h csn=%b expected scl=%b 0 1 0 0 0 1",
                             u, scl_v[u], mosi_v[u], ready_v[u], running_v[u], done_v[u], get_rx(u), csn_v[u], cp);
                end
                @(negedge clk);
                resetn = 1'b1;
                for (int j = 0; j < B + 4; j++) begin
                    @(negedge clk);
                    checks++;
                    if (done_v[u] !== 1'b0 || ready_v[u] !== 1'b1 || scl_v[u] !== cp) begin
                        errors++;
                        $display("FAIL abort_quiet u%0d c%0d: got done=%b rdy=%b scl=%b expected 0 1 %b",
                                 u, j, done_v[u], ready_v[u], scl_v[u], cp);
                    end
                end
                for (int v = 0; v < 3; v++) prev_rx[v] = '0;
                return;
            end
            if (!keep_we) we_v[u] = 1'b0;
            if (c == change_at) set_tx(u, next_tx);

            k = c - 1 - L;
            half = (k >= 0) ? k / D : 0;
            e_run = (c <= B);
            e_scl = cp;
            e_mosi = 1'b0;
            if (k >= 0 && k < 2 * W * D) begin
                e_scl = cp ^ half[0];
                e_mosi = word_bit(word, W, pm(u), half / 2);
            end
            e_rx = prev_rx[u];
            if (c == B + 1) begin
                e_rx = '0;
                for (int i = 0; i < W; i++) begin
                    b = loop_v[u] ? word_bit(word, W, pm(u), i) : samp[L + (2 * i + 1) * D];
                    if (pm(u)) e_rx[W-1-i] = b;
                    else       e_rx[i] = b;
                end
            end

            checks++;
            if (scl_v[u] !== e_scl) begin
                errors++;
                $display("FAIL scl u%0d c%0d: got %b expected %b", u, c, scl_v[u], e_scl);
            end
            checks++;
            if (mosi_v[u] !== e_mosi) begin
                errors++;
                $display("FAIL mosi u%0d c%0d: got %b expected %b", u, c, mosi_v[u], e_mosi);
            end
            checks++;
            if (running_v[u] !== e_run || ready_v[u] !== !e_run) begin
                errors++;
                $display("FAIL run_ready u%0d c%0d: got run=%b rdy=%b expected run=%b", u, c, running_v[u], ready_v[u], e_run);
            end
            checks++;
            if (done_v[u] !== (c == B + 1)) begin
                errors++;
                $display("FAIL done u%0d c%0d: got %b expected %b", u, c, done_v[u], (c == B + 1));
            end
            checks++;
            if (get_rx(u) !== e_rx) begin
                errors++;
                $display("FAIL rx u%0d c%0d: got %0h expected %0h", u, c, get_rx(u), e_rx);
            end
            if (CSEN) begin
                checks++;
                if (csn_v[u] !== !e_run) begin
                    errors++;
                    $display("FAIL cs_n u%0d c%0d: got %b expected %b", u, c, csn_v[u], !e_run);
                end
            end
            prev_rx[u] = e_rx;
            miso_drv[u] = miso_mode ? 1'b1 : 1'($urandom);
            samp[c] = miso_drv[u];
        end
        if (!keep_we) we_v[u] = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (scl_v[u] !== pc(u) || mosi_v[u] !== 1'b0 || ready_v[u] !== 1'b1 ||
                running_v[u] !== 1'b0 || done_v[u] !== 1'b0 || get_rx(u) !== 64'd0 ||
                csn_v[u] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state u%0d: got scl=%b mosi=%b rdy=%b run=%b done=%b rx=%0h csn=%b expected scl=%b 0 1 0 0 0 1",
                         u, scl_v[u], mosi_v[u], ready_v[u], running_v[u], done_v[u], get_rx(u), csn_v[u], pc(u));
            end
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (ready_v[u] !== 1'b1 || scl_v[u] !== pc(u) || mosi_v[u] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset u%0d: got rdy=%b scl=%b mosi=%b expected 1 %b 0",
                         u, ready_v[u], scl_v[u], mosi_v[u], pc(u));
            end
        end
    endtask

    task automatic test_loopback();
        loop_v[0] = 1'b1;
        run_one(0, 64'hA5C381, 1'b0, '0, -1, -1, 1'b0);
        loop_v[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_cpol();
        run_one(1, 64'h3C, 1'b0, '0, -1, -1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        run_one(2, 64'h0001, 1'b0, '0, -1, -1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        int u;
        for (int n = 0; n < 8; n++) begin
            u = int'($urandom_range(0, 2));
            loop_v[u] = 1'($urandom);
            run_one(u, {$urandom, $urandom}, 1'b0, '0, -1, -1, 1'b0);
            loop_v[u] = 1'b0;
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w1, w2;
        w1 = 64'($urandom);
        w2 = 64'($urandom);
        run_one(0, w1, 1'b1, w2, 10, -1, 1'b0);
        run_one(0, w2, 1'b0, '0, -1, -1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_midxfer();
        int L;
        L = CSEN ? pd(0) : 0;
        run_one(0, 64'($urandom), 1'b0, '0, -1, 1 + L + 2 * 10 * pd(0), 1'b0);
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        we_v = '0;
        loop_v = '0;
        miso_drv = '0;
        tx0 = '0; tx1 = '0; tx2 = '0;
        for (int v = 0; v < 3; v++) prev_rx[v] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_loopback();
        test_div_cpol();
        test_lsb_first();
        test_random();
        test_back_to_back();
        test_reset_midxfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
